// File: rtl/udma_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM master port between N_REQ uDMA
// requesters. A request that is presented but not yet granted stays locked.
// An ID FIFO records who was granted, so each in-order rvalid is routed back
// to the requester that issued it.
module udma_l2_port_arbiter #(
  parameter int N_REQ           = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  sys_clk_i,
  input  logic                                  sys_rst_ni,
  input  logic [N_REQ-1:0]                      req_i,
  output logic [N_REQ-1:0]                      gnt_o,
  input  logic [N_REQ-1:0]                      wen_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]    be_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      wdata_i,
  output logic [N_REQ-1:0]                      rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  output logic                                  L2_req_o,
  input  logic                                  L2_gnt_i,
  output logic                                  L2_wen_o,
  output logic [ADDR_WIDTH-1:0]                 L2_addr_o,
  output logic [DATA_WIDTH/8-1:0]               L2_be_o,
  output logic [DATA_WIDTH-1:0]                 L2_wdata_o,
  input  logic                                  L2_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                 L2_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
  output logic                                  err_o,
  input  logic                                  clr_err_i
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = $clog2(MAX_OUTSTANDING+1);

  logic [IDW-1:0] prio_q, prio_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q;

  logic [IDW-1:0] sel_rr, sel, head;
  logic           found, fifo_full, fifo_empty, hs, pop, err_set;
  logic [IDW:0]   idx;

  // Round-robin search starting at prio, wrapping modulo N_REQ.
  always_comb begin
    sel_rr = prio_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, prio_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N_REQ)) idx = idx - (IDW+1)'(N_REQ);
      if (!found && req_i[idx[IDW-1:0]]) begin
        sel_rr = idx[IDW-1:0];
        found  = 1'b1;
      end
    end
  end

  assign sel        = lock_q ? lock_id_q : sel_rr;
  assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rptr_q];

  // A locked request is re-presented even if req_i dropped, but never while full.
  assign L2_req_o   = (lock_q | (|req_i)) & ~fifo_full;
  assign L2_wen_o   = wen_i[sel];
  assign L2_addr_o  = addr_i[sel];
  assign L2_be_o    = be_i[sel];
  assign L2_wdata_o = wdata_i[sel];

  assign hs      = L2_req_o & L2_gnt_i;
  assign pop     = L2_rvalid_i & ~fifo_empty;
  assign err_set = L2_rvalid_i & fifo_empty;

  assign rdata_o       = L2_rdata_i;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  // Grant and response routing, both combinational one-hots.
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (hs)  gnt_o[sel]     = 1'b1;
    if (pop) rvalid_o[head] = 1'b1;
  end

  // Arbitration pointer, lock and FIFO occupancy next state.
  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    cnt_d     = cnt_q;
    if (hs) begin
      prio_d = (sel == IDW'(N_REQ-1)) ? '0 : sel + 1'b1;
      lock_d = 1'b0;
    end else if (L2_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards all outstanding IDs.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      prio_q    <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      cnt_q     <= cnt_d;
      if (hs) begin
        fifo_q[wptr_q] <= sel;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (err_set)        err_q <= 1'b1;
      else if (clr_err_i) err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udma_l2_port_arbiter.sv
// Randomized bench for udma_l2_port_arbiter against a queue-based model of
// the arbitration and response-routing rules.
module tb_udma_l2_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int BW = DW/8;
  localparam int CW = $clog2(MO+1);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N-1:0]              req_i, gnt_o, wen_i, rvalid_o;
  logic [N-1:0][AW-1:0]      addr_i;
  logic [N-1:0][BW-1:0]      be_i;
  logic [N-1:0][DW-1:0]      wdata_i;
  logic [DW-1:0]             rdata_o, L2_rdata_i, L2_wdata_o;
  logic                      L2_req_o, L2_gnt_i, L2_wen_o, L2_rvalid_i;
  logic [AW-1:0]             L2_addr_o;
  logic [BW-1:0]             L2_be_o;
  logic [CW-1:0]             outstanding_o;
  logic                      err_o, clr_err_i;

  always #5 clk = ~clk;

  udma_l2_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .req_i(req_i), .gnt_o(gnt_o), .wen_i(wen_i), .addr_i(addr_i), .be_i(be_i),
    .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .L2_req_o(L2_req_o), .L2_gnt_i(L2_gnt_i), .L2_wen_o(L2_wen_o),
    .L2_addr_o(L2_addr_o), .L2_be_o(L2_be_o), .L2_wdata_o(L2_wdata_o),
    .L2_rvalid_i(L2_rvalid_i), .L2_rdata_i(L2_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o), .clr_err_i(clr_err_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: who was granted (in order), round-robin start, waiting requester.
  int q[$];
  int m_prio;
  bit m_waiting;
  int m_wait_id;
  bit m_err;
  bit pend [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prio    = 0;
    m_waiting = 0;
    m_wait_id = 0;
    m_err     = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  // Drive one cycle of stimulus, check at mid-cycle, then advance the model at the edge.
  task automatic run_cycle(input int req_pct, input int gnt_pct, input int rv_pct, input bit force_sp);
    int sel;
    bit any, full, exp_req, hs, sp;
    logic [N-1:0] exp_gnt, exp_rv;
    logic [DW-1:0] rd;

    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(99) < req_pct) begin
        pend[i]    = 1;
        addr_i[i]  = $urandom;
        wen_i[i]   = 1'($urandom_range(1));
        be_i[i]    = BW'($urandom);
        wdata_i[i] = $urandom;
      end
      req_i[i] = pend[i];
    end
    L2_gnt_i = ($urandom_range(99) < gnt_pct);
    if (q.size() > 0) L2_rvalid_i = ($urandom_range(99) < rv_pct);
    else              L2_rvalid_i = force_sp || ($urandom_range(99) < 3);
    rd         = $urandom;
    L2_rdata_i = rd;
    clr_err_i  = ($urandom_range(99) < 5);

    #4;
    any  = 0;
    for (int i = 0; i < N; i++) any |= pend[i];
    full = (q.size() == MO);
    sel  = m_prio;
    if (m_waiting) sel = m_wait_id;
    else begin
      for (int k = N-1; k >= 0; k--)
        if (pend[(m_prio + k) % N]) sel = (m_prio + k) % N;
    end
    exp_req = (m_waiting || any) && !full;
    hs      = exp_req && L2_gnt_i;
    exp_gnt = hs ? N'(1 << sel) : '0;
    exp_rv  = (L2_rvalid_i && q.size() > 0) ? N'(1 << q[0]) : '0;
    sp      = L2_rvalid_i && (q.size() == 0);

    chk("L2_req", L2_req_o, exp_req);
    chk("gnt", gnt_o, exp_gnt);
    chk("rvalid", rvalid_o, exp_rv);
    chk("rdata", rdata_o, rd);
    chk("outstanding", outstanding_o, q.size());
    chk("err", err_o, m_err);
    if (exp_req) begin
      chk("L2_addr", L2_addr_o, addr_i[sel]);
      chk("L2_wen", L2_wen_o, wen_i[sel]);
      chk("L2_be", L2_be_o, be_i[sel]);
      chk("L2_wdata", L2_wdata_o, wdata_i[sel]);
    end

    @(posedge clk);
    #1;
    if (L2_rvalid_i && q.size() > 0) void'(q.pop_front());
    if (hs) begin
      q.push_back(sel);
      m_prio    = (sel + 1) % N;
      m_waiting = 0;
      pend[sel] = 0;
    end else if (exp_req) begin
      m_waiting = 1;
      m_wait_id = sel;
    end
    m_err = sp || (m_err && !clr_err_i);
  endtask

  // Asynchronous reset in the middle of a cycle; requesters drop with it.
  task automatic do_reset();
    req_i       = '0;
    L2_gnt_i    = 0;
    L2_rvalid_i = 0;
    clr_err_i   = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_L2_req", L2_req_o, 1'b0);
    chk("rst_gnt", gnt_o, '0);
    chk("rst_rvalid", rvalid_o, '0);
    chk("rst_outstanding", outstanding_o, '0);
    chk("rst_err", err_o, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 0;
    req_i       = '0;
    wen_i       = '1;
    addr_i      = '0;
    be_i        = '0;
    wdata_i     = '0;
    L2_gnt_i    = 0;
    L2_rvalid_i = 0;
    L2_rdata_i  = '0;
    clr_err_i   = 0;
    model_reset();
    #12;
    chk("init_L2_req", L2_req_o, 1'b0);
    chk("init_outstanding", outstanding_o, '0);
    chk("init_err", err_o, 1'b0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    for (int c = 0; c < 800; c++) run_cycle(60, 90, 10, 0);
    do_reset();
    run_cycle(0, 0, 0, 1);
    for (int c = 0; c < 800; c++) run_cycle(40, 50, 50, 0);
    do_reset();
    run_cycle(0, 0, 0, 1);
    for (int c = 0; c < 800; c++) run_cycle(90, 100, 80, 0);
    for (int c = 0; c < 400; c++) run_cycle(100, 30, 20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
